// File: rtl/pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// pulse_gen_pkg
// Shared types and defaults for the pulse train generator.
//   pg_state_t        : controller state (IDLE, HIGH, LOW)
//   PG_CNT_W_DEFAULT  : default width of length / count fields
// -----------------------------------------------------------------------------
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pg_state_t;

    localparam int PG_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Down-counter timing one HIGH or LOW phase. Loaded with the phase length at
// phase entry, counts down to 1; 'expired' marks the last cycle of the phase.
// Ports:
//   clk        : clock, posedge
//   reset      : synchronous reset, active low
//   load       : load load_value (takes priority over enable)
//   load_value : phase length, must be >= 1
//   enable     : count down while a phase is running
//   expired    : current cycle is the final cycle of the phase
// -----------------------------------------------------------------------------
module phase_counter
    import pulse_gen_pkg::*;
#(
    parameter int W = PG_CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expired = (count_reg == W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
// On an accepted start, emits NUM pulses on wave_o, each HIGH for H cycles then
// LOW for L cycles. Zero lengths are clamped to 1. Reports busy, a one-cycle
// done on normal completion, and the number of rising edges emitted.
// Ports:
//   clk          : clock, posedge
//   reset        : synchronous reset, active low
//   start_i      : one-cycle train request, only honoured in IDLE
//   high_len_i   : H, latched on accepted start
//   low_len_i    : L, latched on accepted start
//   num_pulses_i : NUM, latched on accepted start
//   abort_i      : cancel an active train (no done)
//   wave_o       : registered waveform
//   busy_o       : train in progress
//   done_o       : one-cycle pulse in the first IDLE cycle after a train
//   edge_cnt_o   : rising edges emitted in the current or last train
// -----------------------------------------------------------------------------
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int CNT_W = PG_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] high_len_i,
    input  logic [CNT_W-1:0] low_len_i,
    input  logic [CNT_W-1:0] num_pulses_i,
    input  logic             abort_i,
    output logic             wave_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] edge_cnt_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    pg_state_t        state_reg, state_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic [CNT_W-1:0] low_reg, low_next;
    logic [CNT_W-1:0] remain_reg, remain_next;   // pulses still to start after the current one
    logic [CNT_W-1:0] edge_reg, edge_next;
    logic             wave_reg, wave_next;
    logic             done_reg, done_next;

    logic             phase_load;
    logic [CNT_W-1:0] phase_value;
    logic             phase_expired;
    logic [CNT_W-1:0] high_clamped, low_clamped;

    assign high_clamped = (high_len_i == '0) ? ONE : high_len_i;
    assign low_clamped  = (low_len_i  == '0) ? ONE : low_len_i;

    phase_counter #(.W(CNT_W)) u_phase (
        .clk        (clk),
        .reset      (reset),
        .load       (phase_load),
        .load_value (phase_value),
        .enable     (state_reg != IDLE),
        .expired    (phase_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= IDLE;
            high_reg   <= '0;
            low_reg    <= '0;
            remain_reg <= '0;
            edge_reg   <= '0;
            wave_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            high_reg   <= high_next;
            low_reg    <= low_next;
            remain_reg <= remain_next;
            edge_reg   <= edge_next;
            wave_reg   <= wave_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        high_next   = high_reg;
        low_next    = low_reg;
        remain_next = remain_reg;
        edge_next   = edge_reg;
        done_next   = 1'b0;
        phase_load  = 1'b0;
        phase_value = high_reg;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    high_next = high_clamped;
                    low_next  = low_clamped;
                    if (num_pulses_i != '0) begin
                        state_next  = HIGH;
                        remain_next = num_pulses_i - ONE;
                        edge_next   = ONE;
                        phase_load  = 1'b1;
                        phase_value = high_clamped;
                    end else begin
                        // Empty train: report completion without going busy.
                        remain_next = '0;
                        edge_next   = '0;
                        done_next   = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (phase_expired) begin
                    state_next  = LOW;
                    phase_load  = 1'b1;
                    phase_value = low_reg;
                end
            end
            LOW: begin
                // Abort wins over completion, so an abort in the last LOW
                // cycle suppresses done.
                if (abort_i) begin
                    state_next = IDLE;
                end else if (phase_expired) begin
                    if (remain_reg != '0) begin
                        state_next  = HIGH;
                        remain_next = remain_reg - ONE;
                        edge_next   = edge_reg + ONE;
                        phase_load  = 1'b1;
                        phase_value = high_reg;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The waveform is registered straight from the next state, so every
        // transition is a single clean flop edge.
        wave_next = (state_next == HIGH);
    end

    assign wave_o     = wave_reg;
    assign busy_o     = (state_reg != IDLE);
    assign done_o     = done_reg;
    assign edge_cnt_o = edge_reg;

endmodule
